// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register/status codes and
// the pipeline controller state encoding.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned STAT_W  = 3;

    localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
    localparam logic [ICODE_W-1:0] IRET    = 4'h9;
    localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SHLT = 3'd2;
    localparam logic [STAT_W-1:0] SADR = 3'd3;
    localparam logic [STAT_W-1:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } ctrl_state_e;

    // Status 0 (uninitialised) and SAOK are both non-exceptional.
    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == SADR) || (s == SHLT) || (s == SINS);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms for the pipeline controller: load-use,
// branch mispredict and a ret in flight.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_Cnd,
    input  logic [ICODE_W-1:0] M_icode,
    output logic               loaduse_c,
    output logic               mispred_c,
    output logic               retp_c
);

    logic e_is_load;

    assign e_is_load = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);

    assign loaduse_c = e_is_load && (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    // Jumps are predicted taken, so a false condition is a mispredict.
    assign mispred_c = (E_icode == IJXX) && !e_Cnd;

    assign retp_c = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard/sequencing controller: post-reset flush, stall and
// bubble generation, halt on exceptional writeback status, perf counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 5,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_Cnd,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    output logic               F_stall,
    output logic               D_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_stall,
    output logic               set_cc_en,
    output logic [STAT_W-1:0]  cpu_stat,
    output logic               halted,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic [CNT_W-1:0]   lu_cnt,
    output logic [CNT_W-1:0]   mp_cnt,
    output logic [CNT_W-1:0]   ret_cnt
);

    localparam int unsigned FC_W = 4;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    ctrl_state_e     state, state_nxt;
    logic [FC_W-1:0] flush_cnt;
    logic            loaduse, mispred, retp;
    logic            m_exc, w_exc;
    logic            cnt_en;

    hazard_detect u_hazard (
        .D_icode   (D_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_icode   (E_icode),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .M_icode   (M_icode),
        .loaduse_c (loaduse),
        .mispred_c (mispred),
        .retp_c    (retp)
    );

    assign m_exc  = is_exc(m_stat);
    assign w_exc  = is_exc(W_stat);
    assign cnt_en = (state == ST_RUN) && !w_exc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FLUSH;
        else        state <= state_nxt;
    end

    // Next state and stall/bubble decode; pipeline controls stay combinational.
    always_comb begin
        state_nxt = state;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        W_stall   = 1'b0;
        set_cc_en = 1'b0;
        case (state)
            ST_FLUSH: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (flush_cnt == FLUSH_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A load-use stall holds decode, so a pending ret cannot bubble it.
                F_stall   = loaduse || retp;
                D_stall   = loaduse;
                D_bubble  = mispred || (!loaduse && retp);
                E_bubble  = mispred || loaduse;
                M_bubble  = m_exc || w_exc;
                W_stall   = w_exc;
                set_cc_en = !m_exc && !w_exc;
                if (w_exc) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            default: state_nxt = ST_FLUSH;
        endcase
    end

    // Flush counter, architectural status and saturating perf counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            cpu_stat  <= SAOK;
            halted    <= 1'b0;
            cyc_cnt   <= '0;
            lu_cnt    <= '0;
            mp_cnt    <= '0;
            ret_cnt   <= '0;
        end else begin
            if (state == ST_FLUSH) flush_cnt <= flush_cnt + FC_W'(1);
            if (state == ST_RUN) begin
                if (w_exc) begin
                    cpu_stat <= W_stat;
                    halted   <= 1'b1;
                end else begin
                    cpu_stat <= SAOK;
                end
            end
            cyc_cnt <= sat_inc(cyc_cnt, cnt_en);
            lu_cnt  <= sat_inc(lu_cnt,  cnt_en && loaduse);
            mp_cnt  <= sat_inc(mp_cnt,  cnt_en && mispred);
            ret_cnt <= sat_inc(ret_cnt, cnt_en && retp && !loaduse);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 32-bit counter instance and a 4-bit counter
// instance share stimulus so counter saturation is reachable quickly.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted;
    logic [2:0]  cpu_stat;
    logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc_en, s_halted;
    logic [2:0]  s_cpu_stat;
    logic [3:0]  s_cyc_cnt, s_lu_cnt, s_mp_cnt, s_ret_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(.FLUSH_CYCLES(5), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc_en(set_cc_en), .cpu_stat(cpu_stat), .halted(halted), .cyc_cnt(cyc_cnt),
        .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    pipe_ctrl #(.FLUSH_CYCLES(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(s_F_stall), .D_stall(s_D_stall),
        .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .W_stall(s_W_stall),
        .set_cc_en(s_set_cc_en), .cpu_stat(s_cpu_stat), .halted(s_halted), .cyc_cnt(s_cyc_cnt),
        .lu_cnt(s_lu_cnt), .mp_cnt(s_mp_cnt), .ret_cnt(s_ret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Quiet pipeline: nops everywhere, no register dependencies, status AOK.
    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA  = 4'hF; d_srcB  = 4'hF; E_dstM  = 4'hF;
        e_Cnd   = 1'b0; m_stat  = 3'd1; W_stat  = 3'd1;
    endtask

    task automatic set_loaduse();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    endtask

    // Compares the seven pipeline-control outputs in one call.
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk({tag, ".F_stall"},   32'(F_stall),   32'(exp[6]));
        chk({tag, ".D_stall"},   32'(D_stall),   32'(exp[5]));
        chk({tag, ".D_bubble"},  32'(D_bubble),  32'(exp[4]));
        chk({tag, ".E_bubble"},  32'(E_bubble),  32'(exp[3]));
        chk({tag, ".M_bubble"},  32'(M_bubble),  32'(exp[2]));
        chk({tag, ".W_stall"},   32'(W_stall),   32'(exp[1]));
        chk({tag, ".set_cc_en"}, 32'(set_cc_en), 32'(exp[0]));
    endtask

    task automatic chk_cnt(input string tag, input int cyc, input int lu, input int mp, input int rt);
        chk({tag, ".cyc_cnt"}, cyc_cnt, 32'(cyc));
        chk({tag, ".lu_cnt"},  lu_cnt,  32'(lu));
        chk({tag, ".mp_cnt"},  mp_cnt,  32'(mp));
        chk({tag, ".ret_cnt"}, ret_cnt, 32'(rt));
    endtask

    // Flush pattern {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc_en}.
    localparam logic [6:0] CTL_FLUSH = 7'b0011100;
    localparam logic [6:0] CTL_HALT  = 7'b1101110;

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_ctl("reset", CTL_FLUSH);
        chk("reset.cpu_stat", 32'(cpu_stat), 32'd1);
        chk("reset.halted", 32'(halted), 32'd0);
        chk_cnt("reset", 0, 0, 0, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk_ctl("flush", CTL_FLUSH);
            @(negedge clk);
        end

        // N0: first RUN cycle, quiet pipeline.
        #1 chk_ctl("run_idle", 7'b0000001);
        chk("run.cpu_stat", 32'(cpu_stat), 32'd1);
        chk_cnt("run_start", 0, 0, 0, 0);

        @(negedge clk);
        chk("n1.cyc_cnt", cyc_cnt, 32'd1);
        idle(); set_loaduse();
        #1 chk_ctl("loaduse", 7'b1101001);

        @(negedge clk);
        chk_cnt("n2", 2, 1, 0, 0);
        idle(); E_icode = 4'h7; e_Cnd = 1'b0;
        #1 chk_ctl("mispred", 7'b0011001);

        @(negedge clk);
        chk_cnt("n3", 3, 1, 1, 0);
        idle(); E_icode = 4'h7; e_Cnd = 1'b1; W_stat = 3'd0;
        #1 chk_ctl("jmp_taken_wstat0", 7'b0000001);

        @(negedge clk);
        chk("n4.mp_cnt", mp_cnt, 32'd1);
        idle(); D_icode = 4'h9;
        #1 chk_ctl("ret_D", 7'b1010001);
        @(negedge clk);
        idle(); E_icode = 4'h9;
        #1 chk_ctl("ret_E", 7'b1010001);
        @(negedge clk);
        idle(); M_icode = 4'h9;
        #1 chk_ctl("ret_M", 7'b1010001);

        @(negedge clk);
        chk_cnt("n7", 7, 1, 1, 3);
        idle(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1 chk_ctl("ret_with_loaduse", 7'b1101001);

        @(negedge clk);
        chk_cnt("n8", 8, 2, 1, 3);
        idle(); set_loaduse();
        repeat (16) @(negedge clk);
        chk_cnt("sat_run", 24, 18, 1, 3);
        chk("sat.lu_cnt4",  32'(s_lu_cnt),  32'd15);
        chk("sat.cyc_cnt4", 32'(s_cyc_cnt), 32'd15);
        chk("sat.ret_cnt4", 32'(s_ret_cnt), 32'd3);

        idle(); m_stat = 3'd3;
        #1 chk_ctl("m_exc", 7'b0000100);

        @(negedge clk);
        chk("n25.cyc_cnt", cyc_cnt, 32'd25);
        idle(); W_stat = 3'd3;
        #1 chk_ctl("w_exc", 7'b0000110);
        chk("w_exc.halted", 32'(halted), 32'd0);
        chk("w_exc.cpu_stat", 32'(cpu_stat), 32'd1);

        @(negedge clk);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.cpu_stat", 32'(cpu_stat), 32'd3);
        idle(); set_loaduse();
        #1 chk_ctl("halt", CTL_HALT);
        repeat (20) @(negedge clk);
        #1 chk_ctl("halt_hold", CTL_HALT);
        chk("halt_hold.halted", 32'(halted), 32'd1);
        chk("halt_hold.cpu_stat", 32'(cpu_stat), 32'd3);
        chk_cnt("halt_hold", 25, 18, 1, 3);

        rst_n = 1'b0;
        @(negedge clk);
        #1 chk_ctl("rereset", CTL_FLUSH);
        chk("rereset.halted", 32'(halted), 32'd0);
        chk("rereset.cpu_stat", 32'(cpu_stat), 32'd1);
        chk_cnt("rereset", 0, 0, 0, 0);
        chk("rereset.lu_cnt4", 32'(s_lu_cnt), 32'd0);

        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 5; i++) begin
            #1 chk_ctl("reflush", CTL_FLUSH);
            @(negedge clk);
        end
        #1 chk_ctl("rerun_idle", 7'b0000001);
        chk("rerun.cyc_cnt", cyc_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
